mii_rx_deframer: RTL
====================

MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, receive data width (8 lanes of 8 bits).
REQ-002 SHALL have parameter CTRL_WIDTH, default 8, one control bit per lane.
REQ-003 SHALL have parameter MAX_WORDS, default 200, maximum payload words per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_rx_data, input, DATA_WIDTH, MII data; lane k = bits [8k+7:8k].
REQ-007 SHALL have port i_rx_ctrl, input, CTRL_WIDTH, bit k set = lane k is a control character.
REQ-008 SHALL have port o_data, output, DATA_WIDTH, extracted payload word; lane 0 = first byte.
REQ-009 SHALL have port o_valid, output, 1, o_data/o_keep/o_last/o_err are valid this cycle.
REQ-010 SHALL have port o_keep, output, CTRL_WIDTH, byte-valid mask; contiguous from bit 0.
REQ-011 SHALL have port o_last, output, 1, final word of a frame.
REQ-012 SHALL have port o_err, output, 1, qualifies o_last; frame is bad.
REQ-013 SHALL have port o_frame_cnt, output, 16, good frames received; wraps at 0xFFFF.
REQ-014 SHALL have port o_err_cnt, output, 16, bad frames received; wraps at 0xFFFF.

Function
REQ-015 SHALL use control codes: IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE.
REQ-016 SHALL recognise a start word only as ctrl=0x01 with lane0=0xFB, lanes1-6=0x55, lane7=0xD5.
REQ-017 SHALL treat ctrl=0x01, lane0=0xFB with any bad preamble/SFD byte as an errored start: increment o_err_cnt, enter DROP, emit nothing.
REQ-018 SHALL implement states IDLE, DATA, DROP. IDLE->DATA on valid start. DATA->IDLE on TERM. DATA->DROP on error. DROP->IDLE on a word with ctrl=0xFF and all lanes 0x07.
REQ-019 SHALL, in DATA, classify a word with ctrl=0x00 as a full payload word.
REQ-020 SHALL, in DATA, treat the lowest set ctrl bit k with lane k=0xFD as terminate. Lanes 0..k-1 are payload. Lanes k+1..7 SHALL be ctrl with 0x07, otherwise the frame is errored.
REQ-021 SHALL treat any other control character in DATA as an error, including 0xFE, 0x07, or a START. A START does not begin a new frame.
REQ-022 SHALL hold each payload word in a one-word buffer until the next input word is classified. This determines o_last/o_err for the held word.
REQ-023 SHALL have fixed latency: a payload word sampled at edge n appears on o_data with o_valid=1 in the cycle after edge n+2, with no gaps. o_valid SHALL NOT assert in the cycle after edge n+1.
REQ-024 SHALL, on terminate in lane k>0, emit the held word (o_last=0) and then the terminate word with o_keep=(1<<k)-1 and o_last=1.
REQ-025 SHALL, on terminate in lane 0, emit the held word with o_keep=0xFF and o_last=1.
REQ-026 SHALL, on error in DATA, emit the held word with o_last=1 and o_err=1 and discard the erroring word's bytes.
REQ-027 SHALL, if an error occurs with no held word, emit no output and only increment o_err_cnt.
REQ-028 SHALL treat terminate in lane 0 directly after the start word (zero payload) as an error. No output; o_err_cnt+1.
REQ-029 SHALL count payload words. If the count exceeds MAX_WORDS, the frame is errored per REQ-026 and the block enters DROP.
REQ-030 SHALL increment o_frame_cnt on the cycle a good o_last is emitted.
REQ-031 SHALL increment o_err_cnt once per bad frame.
REQ-032 SHALL drive o_keep=0xFF on all non-last words.
REQ-033 SHALL drive o_data, o_keep, o_last and o_err to 0 when o_valid=0.
REQ-034 SHALL NOT apply backpressure; every input word is consumed each cycle.

Reset
REQ-035 SHALL, while i_rst=1 (asynchronous), force state IDLE, clear the hold buffer and word count, and drive all outputs and both counters to 0.
REQ-036 SHALL, on reset mid-frame, abandon the frame with no o_last emitted and no counter change. After release, only a new valid start begins a frame.

Verification
REQ-037 Start, 3 full words D0..D2, then T in lane 0 -> three valid words; D2 with o_last=1, keep=0xFF; o_frame_cnt=1.
REQ-038 Start, 1 full word, then T in lane 5 (lanes 6-7 IDLE) -> 2 words; second with keep=0x1F, o_last=1; o_frame_cnt=1.
REQ-039 Start, 2 words, then word with 0xFE in lane 3 -> word 2 with o_last=1, o_err=1; o_err_cnt=1; later frames ignored until an all-IDLE word.
REQ-040 Start word with lane7=0xD4 -> no output, o_err_cnt=1, block stays in DROP until an all-IDLE word.
REQ-041 MAX_WORDS=4, 6 payload words -> 4 words, the 4th with o_last=1, o_err=1 (per REQ-029/026); o_err_cnt=1.
REQ-042 Assert i_rst during payload word 2 -> outputs and counters 0 immediately; after release, a normal frame yields o_frame_cnt=1.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// rtl/mii_rx_deframer.sv - MII receive deframer: strips start/terminate control words, emits payload words
//
// Purpose: consumes one MII word per cycle (8 lanes of data + per-lane control flag), tracks frame
// boundaries and emits payload as a keep/last/err qualified word stream with good/bad frame counters.
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   i_rst        - asynchronous active-high reset
//   i_rx_data    - MII data, lane k = bits [8k+7:8k]
//   i_rx_ctrl    - bit k set = lane k carries a control character
//   o_data       - payload word, lane 0 = first byte (zero when o_valid=0)
//   o_valid      - o_data/o_keep/o_last/o_err valid this cycle
//   o_keep       - contiguous byte-valid mask from bit 0
//   o_last       - final word of a frame
//   o_err        - qualifies o_last, frame is bad
//   o_frame_cnt  - good frames received (wraps)
//   o_err_cnt    - bad frames received (wraps)
module mii_rx_deframer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int MAX_WORDS  = 200
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [CTRL_WIDTH-1:0] o_keep,
  output logic                  o_last,
  output logic                  o_err,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_err_cnt
);

  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_PRE   = 8'h55;
  localparam logic [7:0] C_SFD   = 8'hD5;
  localparam int         CNT_W   = $clog2(MAX_WORDS + 2);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_t;

  state_t                state_q, state_d;
  // Input register: classification always works on the previous cycle's word.
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic [CTRL_WIDTH-1:0] rx_ctrl_q;
  // One-word hold buffer; hold_last_q marks a terminate word that still has to go out as last.
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CTRL_WIDTH-1:0] hold_keep_q, hold_keep_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  hold_last_q, hold_last_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;

  logic [DATA_WIDTH-1:0] out_data_d;
  logic [CTRL_WIDTH-1:0] out_keep_d;
  logic                  out_valid_d, out_last_d, out_err_d;
  logic                  frame_inc, err_inc, data_err;

  // Word decode
  logic                  found, trail_ok, all_idle, preamble_ok, start_hdr, is_term, term_at0;
  logic [7:0]            term_lane;
  logic [CTRL_WIDTH-1:0] part_keep;
  logic [DATA_WIDTH-1:0] part_data;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  cnt_over;

  always_comb begin
    found       = 1'b0;
    trail_ok    = 1'b1;
    term_lane   = 8'h00;
    part_keep   = '0;
    part_data   = '0;
    all_idle    = &rx_ctrl_q;
    preamble_ok = 1'b1;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (rx_data_q[8*i +: 8] != C_IDLE) all_idle = 1'b0;
      if (i > 0 && i < CTRL_WIDTH - 1 && rx_data_q[8*i +: 8] != C_PRE) preamble_ok = 1'b0;
      // Lanes below the lowest control lane are payload; lanes above it must all be IDLE controls.
      if (found) begin
        if (!(rx_ctrl_q[i] && rx_data_q[8*i +: 8] == C_IDLE)) trail_ok = 1'b0;
      end else if (rx_ctrl_q[i]) begin
        found     = 1'b1;
        term_lane = rx_data_q[8*i +: 8];
      end else begin
        part_keep[i]         = 1'b1;
        part_data[8*i +: 8]  = rx_data_q[8*i +: 8];
      end
    end
    if (rx_data_q[DATA_WIDTH-8 +: 8] != C_SFD) preamble_ok = 1'b0;
    start_hdr = (rx_ctrl_q == CTRL_WIDTH'(1)) && (rx_data_q[7:0] == C_START);
    is_term   = found && (term_lane == C_TERM) && trail_ok;
    term_at0  = rx_ctrl_q[0];
    cnt_inc   = word_cnt_q + CNT_W'(1);
    cnt_over  = cnt_inc > MAX_CNT;
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    word_cnt_d   = word_cnt_q;
    out_valid_d  = 1'b0;
    out_data_d   = '0;
    out_keep_d   = '0;
    out_last_d   = 1'b0;
    out_err_d    = 1'b0;
    err_inc      = 1'b0;
    data_err     = 1'b0;

    // A partial terminate word parked last cycle goes out now; the FSM is already back in IDLE.
    if (hold_last_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = hold_data_q;
      out_keep_d   = hold_keep_q;
      out_last_d   = 1'b1;
      hold_valid_d = 1'b0;
      hold_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_hdr) begin
          if (preamble_ok) begin
            state_d    = ST_DATA;
            word_cnt_d = '0;
          end else begin
            err_inc = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_DATA: begin
        if (rx_ctrl_q == '0) begin
          if (cnt_over) begin
            data_err = 1'b1;
          end else begin
            if (hold_valid_q) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_data_q;
              out_keep_d  = '1;
            end
            hold_data_d  = rx_data_q;
            hold_keep_d  = '1;
            hold_valid_d = 1'b1;
            word_cnt_d   = cnt_inc;
          end
        end else if (is_term && term_at0) begin
          // Terminate in lane 0: the held word is the last one; no held word means an empty frame.
          if (hold_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = hold_data_q;
            out_keep_d   = '1;
            out_last_d   = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            data_err = 1'b1;
          end
        end else if (is_term) begin
          if (cnt_over) begin
            data_err = 1'b1;
          end else begin
            if (hold_valid_q) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_data_q;
              out_keep_d  = '1;
            end
            hold_data_d  = part_data;
            hold_keep_d  = part_keep;
            hold_valid_d = 1'b1;
            hold_last_d  = 1'b1;
            state_d      = ST_IDLE;
          end
        end else begin
          data_err = 1'b1;
        end

        // Error: flush the held word as a bad last, drop the offending word.
        if (data_err) begin
          if (hold_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_keep_d  = '1;
            out_last_d  = 1'b1;
            out_err_d   = 1'b1;
          end
          hold_valid_d = 1'b0;
          hold_last_d  = 1'b0;
          err_inc      = 1'b1;
          state_d      = ST_DROP;
        end
      end
      ST_DROP: begin
        if (all_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    frame_inc = out_valid_d && out_last_d && !out_err_d;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      rx_data_q    <= '0;
      rx_ctrl_q    <= '0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      word_cnt_q   <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_keep       <= '0;
      o_last       <= 1'b0;
      o_err        <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      rx_data_q    <= i_rx_data;
      rx_ctrl_q    <= i_rx_ctrl;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      word_cnt_q   <= word_cnt_d;
      o_data       <= out_data_d;
      o_valid      <= out_valid_d;
      o_keep       <= out_keep_d;
      o_last       <= out_last_d;
      o_err        <= out_err_d;
      if (frame_inc) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (err_inc)   o_err_cnt   <= o_err_cnt + 16'd1;
    end
  end

endmodule
